// File: rtl/sindoku_board_ctrl.sv
// Sudoku game core: holds the board, moves the cursor, commits player entries and
// checks the solution sequentially, one cell per cycle, across rows, columns and boxes.
module sindoku_board_ctrl #(
    parameter int unsigned BOX = 3,
    parameter logic [BOX*BOX*BOX*BOX*4-1:0] PUZZLE = '0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       L,
    input  logic       R,
    input  logic       U,
    input  logic       D,
    input  logic       C,
    input  logic       CheckSolu,
    input  logic [3:0] userIn,
    output logic       q_I,
    output logic       q_Solve,
    output logic       q_Check,
    output logic       q_Correct,
    output logic       q_Incorrect,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col,
    output logic [3:0] cur_val,
    output logic       cur_given,
    output logic [4:0] fail_idx
);

    localparam int unsigned N      = BOX * BOX;
    localparam int unsigned CELLS  = N * N;
    localparam int unsigned IDX_W  = $clog2(CELLS);
    localparam int unsigned GROUPS = 3 * N;
    localparam int unsigned VAL_W  = 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_SOLVE,
        S_CHECK,
        S_CORRECT,
        S_INCORRECT
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [4:0]         g_q, g_d;
    logic [3:0]         k_q, k_d;
    logic [N-1:0]       seen_q, seen_d;
    logic [4:0]         fail_q, fail_d;
    logic               chk_prev_q;
    logic [VAL_W-1:0]   board_q [CELLS];
    logic [VAL_W-1:0]   board_d [CELLS];

    logic               chk_rise_c;
    logic [IDX_W-1:0]   cur_idx_c;
    logic [3:0]         chk_row_c;
    logic [3:0]         chk_col_c;
    logic [4:0]         box_c;
    logic [IDX_W-1:0]   chk_idx_c;
    logic [VAL_W-1:0]   chk_val_c;
    logic [N-1:0]       seen_base_c;
    logic [N-1:0]       val_bit_c;
    logic               chk_fail_c;

    assign chk_rise_c = CheckSolu & ~chk_prev_q;
    assign cur_idx_c  = IDX_W'(row_q) * IDX_W'(N) + IDX_W'(col_q);
    assign cur_given  = (PUZZLE[{cur_idx_c, 2'b00} +: 4] != 4'h0);

    // Map checker counters (g,k) onto a board cell: rows, then columns, then boxes.
    always_comb begin
        box_c     = g_q - 5'(2 * N);
        chk_row_c = k_q;
        chk_col_c = k_q;
        if (g_q < 5'(N)) begin
            chk_row_c = 4'(g_q);
            chk_col_c = k_q;
        end else if (g_q < 5'(2 * N)) begin
            chk_row_c = k_q;
            chk_col_c = 4'(g_q - 5'(N));
        end else begin
            chk_row_c = 4'((box_c / 5'(BOX)) * 5'(BOX) + 5'(k_q / 4'(BOX)));
            chk_col_c = 4'((box_c % 5'(BOX)) * 5'(BOX) + 5'(k_q % 4'(BOX)));
        end
    end

    assign chk_idx_c   = IDX_W'(chk_row_c) * IDX_W'(N) + IDX_W'(chk_col_c);
    assign chk_val_c   = board_q[chk_idx_c];
    assign seen_base_c = (k_q == 4'd0) ? '0 : seen_q;
    assign val_bit_c   = N'(1) << (chk_val_c - 4'd1);
    assign chk_fail_c  = (chk_val_c == 4'd0) || ((seen_base_c & val_bit_c) != '0);

    // Next-state, cursor, board write and checker sequencing.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        g_d     = g_q;
        k_d     = k_q;
        seen_d  = seen_q;
        fail_d  = fail_q;
        board_d = board_q;

        case (state_q)
            S_INIT: begin
                if (C) state_d = S_SOLVE;
            end
            S_SOLVE: begin
                if (C && !cur_given && (userIn <= 4'(N))) board_d[cur_idx_c] = userIn;
                if (L)      col_d = (col_q == 4'd0)       ? 4'(N - 1) : col_q - 4'd1;
                else if (R) col_d = (col_q == 4'(N - 1))  ? 4'd0      : col_q + 4'd1;
                else if (U) row_d = (row_q == 4'd0)       ? 4'(N - 1) : row_q - 4'd1;
                else if (D) row_d = (row_q == 4'(N - 1))  ? 4'd0      : row_q + 4'd1;
                if (chk_rise_c) begin
                    state_d = S_CHECK;
                    g_d     = 5'd0;
                    k_d     = 4'd0;
                    fail_d  = 5'd31;
                end
            end
            S_CHECK: begin
                seen_d = seen_base_c | val_bit_c;
                if (chk_fail_c) begin
                    fail_d  = g_q;
                    state_d = S_INCORRECT;
                end else if (k_q == 4'(N - 1)) begin
                    k_d = 4'd0;
                    if (g_q == 5'(GROUPS - 1)) state_d = S_CORRECT;
                    else                       g_d     = g_q + 5'd1;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_CORRECT: begin
                state_d = S_CORRECT;
            end
            S_INCORRECT: begin
                if (!CheckSolu) state_d = S_SOLVE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_INIT;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            g_q        <= 5'd0;
            k_q        <= 4'd0;
            seen_q     <= '0;
            fail_q     <= 5'd31;
            chk_prev_q <= 1'b1;
            for (int i = 0; i < CELLS; i++) board_q[i] <= PUZZLE[4*i +: 4];
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            g_q        <= g_d;
            k_q        <= k_d;
            seen_q     <= seen_d;
            fail_q     <= fail_d;
            chk_prev_q <= CheckSolu;
            board_q    <= board_d;
        end
    end

    assign q_I         = (state_q == S_INIT);
    assign q_Solve     = (state_q == S_SOLVE);
    assign q_Check     = (state_q == S_CHECK);
    assign q_Correct   = (state_q == S_CORRECT);
    assign q_Incorrect = (state_q == S_INCORRECT);
    assign cur_row     = row_q;
    assign cur_col     = col_q;
    assign cur_val     = board_q[cur_idx_c];
    assign fail_idx    = fail_q;

endmodule

// File: tb/tb_sindoku_board_ctrl.sv
// Self-checking bench for sindoku_board_ctrl (BOX=3) with a behavioural board/cursor model
// and a group-by-group reference checker.
module tb_sindoku_board_ctrl;

    localparam int unsigned N     = 9;
    localparam int unsigned CELLS = 81;

    function automatic int sol_val(input int r, input int c);
        return ((r * 3 + r / 3 + c + 4) % 9) + 1;
    endfunction

    function automatic logic [323:0] mk_puzzle();
        logic [323:0] p;
        p = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                if (((r + c) % 3) == 0) p[4*(r*9+c) +: 4] = 4'(sol_val(r, c));
        return p;
    endfunction

    localparam logic [323:0] PUZ = mk_puzzle();

    logic       Clk, Reset, L, R, U, D, C, CheckSolu;
    logic [3:0] userIn;
    logic       q_I, q_Solve, q_Check, q_Correct, q_Incorrect;
    logic [3:0] cur_row, cur_col, cur_val;
    logic       cur_given;
    logic [4:0] fail_idx;

    sindoku_board_ctrl #(.BOX(3), .PUZZLE(PUZ)) dut (
        .Clk(Clk), .Reset(Reset), .L(L), .R(R), .U(U), .D(D), .C(C),
        .CheckSolu(CheckSolu), .userIn(userIn),
        .q_I(q_I), .q_Solve(q_Solve), .q_Check(q_Check), .q_Correct(q_Correct),
        .q_Incorrect(q_Incorrect), .cur_row(cur_row), .cur_col(cur_col),
        .cur_val(cur_val), .cur_given(cur_given), .fail_idx(fail_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mb [CELLS];
    int   mr, mc, mstate;    // mstate: 0 init, 1 solve, 2 check, 3 correct, 4 incorrect
    logic mprev;

    function automatic int puz(input int i);
        logic [3:0] v;
        v = PUZ[4*i +: 4];
        return int'(v);
    endfunction

    function automatic bit given(input int r, input int c);
        return puz(r * 9 + c) != 0;
    endfunction

    function automatic logic [4:0] flags_of(input int s);
        logic [4:0] f;
        f = 5'b10000 >> s;
        return f;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) mb[i] = puz(i);
        mr = 0; mc = 0; mstate = 0; mprev = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; L = 0; R = 0; U = 0; D = 0; C = 0; userIn = 4'd0;
        step();
        Reset = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of buttons and advance the model by the game rules.
    task automatic press(input bit l, input bit r, input bit u, input bit d, input bit c,
                         input logic [3:0] v);
        int nst;
        nst = mstate;
        L = l; R = r; U = u; D = d; C = c; userIn = v;
        if (mstate == 0) begin
            if (c) nst = 1;
        end else if (mstate == 1) begin
            if (c && !given(mr, mc) && int'(v) <= 9) mb[mr*9+mc] = int'(v);
            if (l)      mc = (mc + 8) % 9;
            else if (r) mc = (mc + 1) % 9;
            else if (u) mr = (mr + 8) % 9;
            else if (d) mr = (mr + 1) % 9;
            if (CheckSolu && !mprev) nst = 2;
        end else if (mstate == 4) begin
            if (!CheckSolu) nst = 1;
        end
        mprev = CheckSolu;
        step();
        L = 0; R = 0; U = 0; D = 0; C = 0;
        mstate = nst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) press(0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic goto_cell(input int r, input int c);
        while (mc != c) press(0, 1, 0, 0, 0, 4'd0);
        while (mr != r) press(0, 0, 0, 1, 0, 4'd0);
    endtask

    task automatic fill_solution(input bit skip_last);
        for (int i = 0; i < CELLS; i++) begin
            if (skip_last && i == CELLS - 1) continue;
            if (!given(i / 9, i % 9) && mb[i] != sol_val(i / 9, i % 9)) begin
                goto_cell(i / 9, i % 9);
                press(0, 0, 0, 0, 1, 4'(sol_val(i / 9, i % 9)));
            end
        end
    endtask

    // Reference checker: scan groups in order, report first failing group and cycle count.
    task automatic model_check(output int fg, output int cycles);
        bit seen [10];
        int r, c, v, b;
        fg = 31;
        cycles = 3 * N * N;
        for (int g = 0; g < 27; g++) begin
            for (int s = 0; s < 10; s++) seen[s] = 0;
            for (int k = 0; k < 9; k++) begin
                if (g < 9)       begin r = g; c = k; end
                else if (g < 18) begin r = k; c = g - 9; end
                else begin
                    b = g - 18;
                    r = (b / 3) * 3 + k / 3;
                    c = (b % 3) * 3 + k % 3;
                end
                v = mb[r*9+c];
                if (v == 0 || seen[v]) begin
                    fg = g;
                    cycles = g * 9 + k + 1;
                    return;
                end
                seen[v] = 1;
            end
        end
    endtask

    task automatic wait_check(output int cnt);
        cnt = 0;
        while (q_Check === 1'b1 && cnt < 1000) begin
            cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        CheckSolu = 1'b0;
        do_reset();
        n_tests++;
        if ({q_I, q_Solve, q_Check, q_Correct, q_Incorrect} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 10000", {q_I, q_Solve, q_Check, q_Correct, q_Incorrect});
        end
        n_tests++;
        if (cur_row !== 4'd0 || cur_col !== 4'd0) begin
            n_fail++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
        n_tests++;
        if (cur_val !== 4'd5 || cur_given !== 1'b1) begin
            n_fail++; $display("FAIL reset_cell: got val=%0d given=%b want val=5 given=1", cur_val, cur_given);
        end
        n_tests++;
        if (fail_idx !== 5'd31) begin
            n_fail++; $display("FAIL reset_fail_idx: got %0d want 31", fail_idx);
        end
        press(1, 0, 0, 1, 0, 4'd0);
        n_tests++;
        if (cur_row !== 4'd0 || cur_col !== 4'd0 || q_I !== 1'b1) begin
            n_fail++; $display("FAIL init_ignores_moves: got (%0d,%0d) q_I=%b want (0,0) q_I=1", cur_row, cur_col, q_I);
        end
    endtask

    task automatic test_moves();
        press(0, 0, 0, 0, 1, 4'd0);
        n_tests++;
        if (q_Solve !== 1'b1) begin
            n_fail++; $display("FAIL enter_solve: got q_Solve=%b want 1", q_Solve);
        end
        press(1, 0, 0, 0, 0, 4'd0);
        n_tests++;
        if (cur_row !== 4'd0 || cur_col !== 4'd8) begin
            n_fail++; $display("FAIL wrap_left: got (%0d,%0d) want (0,8)", cur_row, cur_col);
        end
        press(0, 0, 1, 0, 0, 4'd0);
        n_tests++;
        if (cur_row !== 4'd8 || cur_col !== 4'd8) begin
            n_fail++; $display("FAIL wrap_up: got (%0d,%0d) want (8,8)", cur_row, cur_col);
        end
        press(1, 0, 0, 1, 0, 4'd0);
        n_tests++;
        if (cur_row !== 4'd8 || cur_col !== 4'd7) begin
            n_fail++; $display("FAIL move_priority: got (%0d,%0d) want (8,7)", cur_row, cur_col);
        end
    endtask

    task automatic test_writes();
        press(0, 0, 0, 0, 1, 4'd7);
        n_tests++;
        if (cur_val !== 4'(puz(8 * 9 + 7))) begin
            n_fail++; $display("FAIL write_given: got %0d want %0d", cur_val, puz(8 * 9 + 7));
        end
        press(0, 1, 0, 0, 0, 4'd0);
        press(0, 0, 0, 0, 1, 4'd10);
        n_tests++;
        if (cur_val !== 4'd0 || cur_given !== 1'b0) begin
            n_fail++; $display("FAIL write_over_n: got val=%0d given=%b want val=0 given=0", cur_val, cur_given);
        end
        press(0, 0, 0, 0, 1, 4'd4);
        n_tests++;
        if (cur_val !== 4'd4) begin
            n_fail++; $display("FAIL write_blank: got %0d want 4", cur_val);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            press($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
            n_tests++;
            if ({cur_row, cur_col, cur_val, cur_given, q_Solve} !==
                {4'(mr), 4'(mc), 4'(mb[mr*9+mc]), given(mr, mc), 1'b1}) begin
                n_fail++;
                if (errs++ < 5)
                    $display("FAIL random_%0d: got (%0d,%0d) val=%0d given=%b solve=%b want (%0d,%0d) val=%0d given=%b solve=1",
                             i, cur_row, cur_col, cur_val, cur_given, q_Solve, mr, mc, mb[mr*9+mc], given(mr, mc));
            end
        end
    endtask

    task automatic test_check_valid();
        int fg, cyc, cnt;
        fill_solution(1);
        goto_cell(8, 8);
        CheckSolu = 1'b1;
        press(0, 0, 0, 0, 1, 4'(sol_val(8, 8)));
        model_check(fg, cyc);
        n_tests++;
        if (q_Check !== 1'b1) begin
            n_fail++; $display("FAIL check_entry: got q_Check=%b want 1", q_Check);
        end
        wait_check(cnt);
        mstate = (fg == 31) ? 3 : 4;
        n_tests++;
        if (cnt != cyc) begin
            n_fail++; $display("FAIL check_valid_cycles: got %0d want %0d", cnt, cyc);
        end
        n_tests++;
        if ({q_I, q_Solve, q_Check, q_Correct, q_Incorrect} !== flags_of(mstate) || fail_idx !== 5'(fg)) begin
            n_fail++; $display("FAIL check_valid_result: got flags=%b fail_idx=%0d want flags=%b fail_idx=%0d",
                               {q_I, q_Solve, q_Check, q_Correct, q_Incorrect}, fail_idx, flags_of(mstate), fg);
        end
        CheckSolu = 1'b0;
        press(1, 0, 0, 0, 1, 4'd1);
        idle(3);
        n_tests++;
        if (q_Correct !== 1'b1 || cur_row !== 4'(mr) || cur_col !== 4'(mc)) begin
            n_fail++; $display("FAIL correct_terminal: got q_Correct=%b (%0d,%0d) want 1 (%0d,%0d)",
                               q_Correct, cur_row, cur_col, mr, mc);
        end
    endtask

    task automatic test_check_fail();
        int fg, cyc, cnt;
        do_reset();
        press(0, 0, 0, 0, 1, 4'd0);
        fill_solution(0);
        goto_cell(4, 0);
        press(0, 0, 0, 0, 1, 4'(sol_val(4, 1)));
        CheckSolu = 1'b1;
        idle(1);
        model_check(fg, cyc);
        wait_check(cnt);
        mstate = (fg == 31) ? 3 : 4;
        n_tests++;
        if (cnt != cyc) begin
            n_fail++; $display("FAIL check_dup_cycles: got %0d want %0d", cnt, cyc);
        end
        n_tests++;
        if (q_Incorrect !== 1'b1 || fail_idx !== 5'(fg)) begin
            n_fail++; $display("FAIL check_dup_result: got q_Incorrect=%b fail_idx=%0d want 1 %0d", q_Incorrect, fail_idx, fg);
        end
        idle(2);
        n_tests++;
        if (q_Incorrect !== 1'b1) begin
            n_fail++; $display("FAIL incorrect_holds: got q_Incorrect=%b want 1", q_Incorrect);
        end
        CheckSolu = 1'b0;
        idle(1);
        n_tests++;
        if (q_Solve !== 1'b1 || fail_idx !== 5'(fg)) begin
            n_fail++; $display("FAIL back_to_solve: got q_Solve=%b fail_idx=%0d want 1 %0d", q_Solve, fail_idx, fg);
        end
        CheckSolu = 1'b1;
        idle(1);
        n_tests++;
        if (q_Check !== 1'b1 || fail_idx !== 5'd31) begin
            n_fail++; $display("FAIL recheck_clears: got q_Check=%b fail_idx=%0d want 1 31", q_Check, fail_idx);
        end
        wait_check(cnt);
        mstate = 4;
        CheckSolu = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid_check();
        int errs, bad_i, bad_v;
        goto_cell(4, 0);
        press(0, 0, 0, 0, 1, 4'(sol_val(4, 0)));
        CheckSolu = 1'b1;
        idle(1);
        for (int i = 0; i < 100; i++) step();
        n_tests++;
        if (q_Check !== 1'b1) begin
            n_fail++; $display("FAIL still_checking: got q_Check=%b want 1", q_Check);
        end
        do_reset();
        n_tests++;
        if ({q_I, q_Solve, q_Check, q_Correct, q_Incorrect} !== 5'b10000 || cur_row !== 4'd0 ||
            cur_col !== 4'd0 || fail_idx !== 5'd31) begin
            n_fail++; $display("FAIL mid_check_reset: got flags=%b (%0d,%0d) fail_idx=%0d want 10000 (0,0) 31",
                               {q_I, q_Solve, q_Check, q_Correct, q_Incorrect}, cur_row, cur_col, fail_idx);
        end
        press(0, 0, 0, 0, 1, 4'd0);
        idle(3);
        n_tests++;
        if (q_Solve !== 1'b1) begin
            n_fail++; $display("FAIL switch_high_at_reset: got q_Solve=%b q_Check=%b want 1 0", q_Solve, q_Check);
        end
        errs = 0; bad_i = 0; bad_v = 0;
        for (int i = 0; i < CELLS; i++) begin
            goto_cell(i / 9, i % 9);
            if (cur_val !== 4'(puz(i))) begin
                if (errs == 0) begin bad_i = i; bad_v = int'(cur_val); end
                errs++;
            end
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++; $display("FAIL board_restored: %0d cells differ, cell %0d got %0d want %0d", errs, bad_i, bad_v, puz(bad_i));
        end
        CheckSolu = 1'b0;
        idle(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; L = 0; R = 0; U = 0; D = 0; C = 0; CheckSolu = 0; userIn = 4'd0;
        step();
        test_reset();
        test_moves();
        test_writes();
        test_random();
        test_check_valid();
        test_check_fail();
        test_reset_mid_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
